// File: rtl/pe_load_ctrl.sv
// Load controller for a processing element: streams an address phase then a data phase
// into the PE pipeline, strobes compute, and waits for the PE to finish.
module pe_load_ctrl #(
   parameter int unsigned DATA_WIDTH = 24,
   parameter int unsigned MAX_BEATS  = 16,
   localparam int unsigned BW        = $clog2(MAX_BEATS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [BW-1:0]         addr_beats_i,
   input  logic [BW-1:0]         data_beats_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] s_data_i,
   output logic                  pipe_enable_o,
   output logic [DATA_WIDTH-1:0] pipe_data_o,
   output logic                  pipe_compute_o,
   input  logic                  pe_done_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  cfg_err_o
);

   typedef enum logic [2:0] {
      StIdle,
      StLoadAddr,
      StLoadData,
      StCompute,
      StWaitDone
   } state_e;

   localparam logic [BW-1:0] MaxBeatsW = BW'(MAX_BEATS);

   state_e                state_q, state_d;
   logic [BW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         addr_beats_q, addr_beats_d;
   logic [BW-1:0]         data_beats_q, data_beats_d;
   logic                  pipe_enable_q, pipe_enable_d;
   logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
   logic                  pipe_compute_q, pipe_compute_d;
   logic                  done_q, done_d;
   logic                  cfg_err_q, cfg_err_d;

   logic                  accept;
   logic                  cfg_ok;
   logic [BW-1:0]         cnt_inc;

   assign cfg_ok = (addr_beats_i != '0) && (addr_beats_i <= MaxBeatsW) &&
                   (data_beats_i != '0) && (data_beats_i <= MaxBeatsW);

   // Ready is bounded by the latched count, so the counter can never pass it or wrap.
   always_comb begin
      s_ready_o = 1'b0;
      if (state_q == StLoadAddr) begin
         s_ready_o = (cnt_q < addr_beats_q);
      end else if (state_q == StLoadData) begin
         s_ready_o = (cnt_q < data_beats_q);
      end
   end

   assign accept  = s_valid_i & s_ready_o;
   assign cnt_inc = cnt_q + BW'(1);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      addr_beats_d   = addr_beats_q;
      data_beats_d   = data_beats_q;
      pipe_enable_d  = accept & ~abort_i;
      pipe_data_d    = pipe_data_q;
      pipe_compute_d = 1'b0;
      done_d         = 1'b0;
      cfg_err_d      = 1'b0;

      if (pipe_enable_d) begin
         pipe_data_d = s_data_i;
      end

      // Abort wins over everything once a job is running, including pe_done_i.
      if (state_q != StIdle && abort_i) begin
         state_d        = StIdle;
         cnt_d          = '0;
         pipe_compute_d = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (cfg_ok) begin
                     addr_beats_d = addr_beats_i;
                     data_beats_d = data_beats_i;
                     cnt_d        = '0;
                     state_d      = StLoadAddr;
                  end else begin
                     cfg_err_d = 1'b1;
                  end
               end
            end
            StLoadAddr: begin
               if (accept) begin
                  if (cnt_inc == addr_beats_q) begin
                     cnt_d   = '0;
                     state_d = StLoadData;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end
            end
            StLoadData: begin
               if (accept) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == data_beats_q) begin
                     state_d = StCompute;
                  end
               end
            end
            StCompute: begin
               pipe_compute_d = 1'b1;
               state_d        = StWaitDone;
            end
            StWaitDone: begin
               if (pe_done_i) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         cnt_q          <= '0;
         addr_beats_q   <= '0;
         data_beats_q   <= '0;
         pipe_enable_q  <= 1'b0;
         pipe_data_q    <= '0;
         pipe_compute_q <= 1'b0;
         done_q         <= 1'b0;
         cfg_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         addr_beats_q   <= addr_beats_d;
         data_beats_q   <= data_beats_d;
         pipe_enable_q  <= pipe_enable_d;
         pipe_data_q    <= pipe_data_d;
         pipe_compute_q <= pipe_compute_d;
         done_q         <= done_d;
         cfg_err_q      <= cfg_err_d;
      end
   end

   assign busy_o         = (state_q != StIdle);
   assign pipe_enable_o  = pipe_enable_q;
   assign pipe_data_o    = pipe_data_q;
   assign pipe_compute_o = pipe_compute_q;
   assign done_o         = done_q;
   assign cfg_err_o      = cfg_err_q;

endmodule

// File: doc/pe_load_ctrl.md
PE_LOAD_CTRL -- requirements
Module: pe_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, the stream and pipeline word width.
REQ-002 SHALL have parameter MAX_BEATS, default 16, the maximum number of beats per load phase; BW = $clog2(MAX_BEATS+1).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1 bit: job start request.
REQ-006 SHALL have port abort_i, input, 1 bit: synchronous job abort.
REQ-007 SHALL have port addr_beats_i, input, BW bits: address-phase beat count, sampled at start.
REQ-008 SHALL have port data_beats_i, input, BW bits: data-phase beat count, sampled at start.
REQ-009 SHALL have port s_valid_i, input, 1 bit: upstream word valid.
REQ-010 SHALL have port s_ready_o, output, 1 bit: upstream word accepted.
REQ-011 SHALL have port s_data_i, input, DATA_WIDTH bits: upstream word.
REQ-012 SHALL have port pipe_enable_o, output, 1 bit: drives the data pipeline enable.
REQ-013 SHALL have port pipe_data_o, output, DATA_WIDTH bits: drives the data pipeline data.
REQ-014 SHALL have port pipe_compute_o, output, 1 bit: drives the data pipeline compute/reset strobe.
REQ-015 SHALL have port pe_done_i, input, 1 bit: PE reports the compute pass is finished.
REQ-016 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-017 SHALL have port done_o, output, 1 bit: one-cycle job-complete pulse.
REQ-018 SHALL have port cfg_err_o, output, 1 bit: one-cycle illegal-config pulse.

Function
REQ-019 SHALL implement the states IDLE, LOAD_ADDR, LOAD_DATA, COMPUTE and WAIT_DONE.
REQ-020 SHALL, in IDLE, on start_i with both beat counts in 1..MAX_BEATS, latch both counts, clear the beat counter and go to LOAD_ADDR.
REQ-021 SHALL, in IDLE, on start_i with either count equal to 0 or greater than MAX_BEATS, pulse cfg_err_o for one cycle and stay in IDLE.
REQ-022 SHALL drive s_ready_o combinationally: high only in LOAD_ADDR or LOAD_DATA while the beat counter is less than the latched count for that phase.
REQ-023 SHALL count a beat as accepted only on a cycle where s_valid_i and s_ready_o are both high.
REQ-024 SHALL register each accepted beat: on the next cycle pipe_enable_o=1 and pipe_data_o=s_data_i (1-cycle latency).
REQ-025 SHALL drive pipe_enable_o=0 on every cycle that follows a non-accepting cycle, and SHALL hold pipe_data_o at its last value on those cycles.
REQ-026 SHALL, in LOAD_ADDR, when the accepting beat is beat number addr_beats, clear the counter and go to LOAD_DATA; beats in adjacent phases may therefore be back-to-back with no gap.
REQ-027 SHALL, in LOAD_DATA, when the accepting beat is beat number data_beats, go to COMPUTE.
REQ-028 SHALL, in COMPUTE, assert pipe_compute_o for exactly one cycle, then go to WAIT_DONE; that cycle is the cycle after the last pipe_enable_o pulse.
REQ-029 SHALL, in WAIT_DONE, on pe_done_i pulse done_o for one cycle (registered) and return to IDLE.
REQ-030 SHALL ignore pe_done_i in all states other than WAIT_DONE.
REQ-031 SHALL ignore start_i while busy_o=1.
REQ-032 SHALL, on abort_i in any non-IDLE state, go to IDLE, pulse pipe_compute_o for one cycle, force pipe_enable_o=0, and not pulse done_o.
REQ-033 SHALL treat abort_i in IDLE as a no-op, with no pipe_compute_o pulse.
REQ-034 SHALL, when abort_i and start_i are both high in IDLE, accept the start.
REQ-035 SHALL, when abort_i and pe_done_i are both high in WAIT_DONE, give abort priority, so done_o is not asserted.
REQ-036 SHALL size the beat counter to BW bits and prevent it from wrapping.

Reset
REQ-037 SHALL, while rst_ni=0, immediately force: state=IDLE, counters and latched counts=0, s_ready_o=0, pipe_enable_o=0, pipe_data_o=0, pipe_compute_o=0, busy_o=0, done_o=0, cfg_err_o=0.
REQ-038 SHALL, on reset asserted mid-job, discard the job with no done_o after release.
REQ-039 SHALL accept start_i on the first clock edge after rst_ni rises.

Verification
REQ-040 SHALL be tested as follows: addr_beats=2, data_beats=3, s_valid_i held high, pe_done_i two cycles after COMPUTE -> pipe_enable_o high for 5 consecutive cycles with data in order, one pipe_compute_o, one done_o.
REQ-041 SHALL be tested as follows: same job with s_valid_i low on every other cycle -> 5 enable pulses with gaps, no beat lost or duplicated, final counts exact.
REQ-042 SHALL be tested as follows: start_i with addr_beats=0, and separately data_beats=17 -> cfg_err_o pulses, busy_o stays 0.
REQ-043 SHALL be tested as follows: abort_i after the 3rd beat of a 4/4 job -> IDLE next cycle, one pipe_compute_o, s_ready_o=0, no done_o; a new job then runs clean.
REQ-044 SHALL be tested as follows: abort_i and pe_done_i in the same cycle, plus start_i while busy -> no done_o, and the start is ignored.
REQ-045 SHALL be tested as follows: rst_ni low mid LOAD_DATA -> all outputs 0 asynchronously, and after release no done_o until a new start.
